// File: rtl/qoi_pkg.sv
// Shared QOI definitions: op byte constants, pixel type, encoder state
// and the colour hash used to address the index table.
package qoi_pkg;

    localparam logic [7:0] QOI_OP_INDEX = 8'h00;
    localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
    localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
    localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
    localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
    localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;
    localparam logic [7:0] QOI_MASK_2   = 8'hC0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } qoi_px_t;

    localparam qoi_px_t QOI_PX_INIT = '{8'h00, 8'h00, 8'h00, 8'hFF};

    // PASS: accepting pixels. SPLIT: a RUN op is out, the pixel that broke
    // the run is parked and gets encoded on the next output advance.
    typedef enum logic [0:0] {
        ST_PASS  = 1'b0,
        ST_SPLIT = 1'b1
    } qoi_state_e;

    // Index position: (r*3 + g*5 + b*7 + a*11) mod 64. The low 6 bits of an
    // 8-bit wrapping sum are the same as those of the full-width sum.
    function automatic logic [5:0] qoi_hash(input qoi_px_t px);
        logic [7:0] s;
        s = px.r * 8'd3 + px.g * 8'd5 + px.b * 8'd7 + px.a * 8'd11;
        return s[5:0];
    endfunction

endpackage

// File: rtl/qoi_index_table.sv
// 64-entry table of recently seen pixels. Combinational read, synchronous
// write, synchronous clear of every entry (clear wins over write).
// With INDEX_EN == 0 the storage is removed and reads return zero.
import qoi_pkg::*;

module qoi_index_table #(
    parameter int INDEX_EN = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       we,
    input  logic [5:0] waddr,
    input  qoi_px_t    wdata,
    input  logic [5:0] raddr,
    output qoi_px_t    rdata
);

    generate
        if (INDEX_EN != 0) begin : g_table
            qoi_px_t mem [64];

            // Clear-all on reset or end of image, otherwise single-entry write.
            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int i = 0; i < 64; i++) begin
                        mem[i] <= '0;
                    end
                end else if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            assign rdata = mem[raddr];
        end else begin : g_none
            logic unused_ok;
            assign unused_ok = ^{clk, clear, we, waddr, wdata, raddr};
            assign rdata     = '0;
        end
    endgenerate

endmodule

// File: rtl/qoi_stream_encoder.sv
// Streaming QOI encoder: one pixel in, at most one op (1..5 bytes) out per
// beat. Ops are left-aligned in out_data, MSB first, unused bytes zero.
//
// Handshake (both sides): a transfer happens on a clk edge where
// valid && ready. A producer holding valid keeps its payload stable until
// the transfer; ready may change freely. The output register advances
// whenever it is empty or being consumed, and the input is only ready in
// PASS state when the output register can advance.
import qoi_pkg::*;

module qoi_stream_encoder #(
    parameter int CHANNELS = 4,
    parameter int RUN_MAX  = 62,
    parameter int INDEX_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic [7:0]  in_a,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [39:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output qoi_state_e  dbg_state
);

    localparam logic [5:0] RUN_MAX6 = RUN_MAX[5:0];

    qoi_state_e state;
    qoi_px_t    prev;
    qoi_px_t    pend_px;
    logic       pend_last;
    logic [5:0] run;

    qoi_px_t    in_px;
    qoi_px_t    enc_px;
    qoi_px_t    idx_px;
    logic [5:0] enc_h;
    logic [5:0] run_inc;
    logic       advance;
    logic       accept;
    logic       is_match;
    logic       idx_hit;
    logic       eoi_load;
    logic       tbl_we;
    logic       tbl_clear;

    logic [7:0]  dr, dg, db;
    logic [7:0]  dr_b, dg_b, db_b;
    logic [7:0]  dg_l, rg_l, bg_l;
    logic [39:0] enc_data;
    logic [2:0]  enc_bytes;

    assign in_px     = '{in_r, in_g, in_b, (CHANNELS == 3) ? 8'hFF : in_a};
    assign advance   = !out_valid || out_ready;
    assign in_ready  = (state == ST_PASS) && advance && rst;
    assign accept    = in_valid && in_ready;
    assign is_match  = (in_px == prev);
    assign run_inc   = run + 6'd1;
    assign dbg_state = state;

    // The parked pixel is encoded in SPLIT, the incoming one otherwise.
    assign enc_px  = (state == ST_SPLIT) ? pend_px : in_px;
    assign enc_h   = qoi_hash(enc_px);
    assign idx_hit = (INDEX_EN != 0) && (idx_px == enc_px);

    // Image ends when the op carrying out_last is loaded. A split with
    // in_last defers the end to the second beat.
    assign eoi_load = rst && advance &&
                      (((state == ST_SPLIT) && pend_last) ||
                       ((state == ST_PASS) && accept && in_last &&
                        (is_match || run == 6'd0)));

    assign tbl_we    = rst && advance &&
                       ((state == ST_SPLIT) ||
                        (accept && !is_match && run == 6'd0));
    assign tbl_clear = !rst || eoi_load;

    qoi_index_table #(
        .INDEX_EN(INDEX_EN)
    ) u_index (
        .clk   (clk),
        .clear (tbl_clear),
        .we    (tbl_we),
        .waddr (enc_h),
        .wdata (enc_px),
        .raddr (enc_h),
        .rdata (idx_px)
    );

    // Non-run op selection: INDEX, then DIFF/LUMA/RGB when alpha is
    // unchanged, else RGBA. Biased differences compare as unsigned ranges.
    always_comb begin
        dr        = enc_px.r - prev.r;
        dg        = enc_px.g - prev.g;
        db        = enc_px.b - prev.b;
        dr_b      = dr + 8'd2;
        dg_b      = dg + 8'd2;
        db_b      = db + 8'd2;
        dg_l      = dg + 8'd32;
        rg_l      = dr - dg + 8'd8;
        bg_l      = db - dg + 8'd8;
        enc_data  = '0;
        enc_bytes = 3'd0;
        if (idx_hit) begin
            enc_data  = {QOI_OP_INDEX | {2'b00, enc_h}, 32'h0};
            enc_bytes = 3'd1;
        end else if (enc_px.a == prev.a) begin
            if (dr_b < 8'd4 && dg_b < 8'd4 && db_b < 8'd4) begin
                enc_data  = {QOI_OP_DIFF | {2'b00, dr_b[1:0], dg_b[1:0], db_b[1:0]}, 32'h0};
                enc_bytes = 3'd1;
            end else if (dg_l < 8'd64 && rg_l < 8'd16 && bg_l < 8'd16) begin
                enc_data  = {QOI_OP_LUMA | {2'b00, dg_l[5:0]}, rg_l[3:0], bg_l[3:0], 24'h0};
                enc_bytes = 3'd2;
            end else begin
                enc_data  = {QOI_OP_RGB, enc_px.r, enc_px.g, enc_px.b, 8'h00};
                enc_bytes = 3'd4;
            end
        end else begin
            enc_data  = {QOI_OP_RGBA, enc_px.r, enc_px.g, enc_px.b, enc_px.a};
            enc_bytes = 3'd5;
        end
    end

    // Encoder state machine with the registered output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_PASS;
            prev      <= QOI_PX_INIT;
            run       <= 6'd0;
            pend_px   <= QOI_PX_INIT;
            pend_last <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= 3'd0;
            out_last  <= 1'b0;
        end else if (advance) begin
            if (state == ST_SPLIT) begin
                out_valid <= 1'b1;
                out_data  <= enc_data;
                out_bytes <= enc_bytes;
                out_last  <= pend_last;
                prev      <= pend_last ? QOI_PX_INIT : pend_px;
                state     <= ST_PASS;
            end else if (accept) begin
                if (is_match) begin
                    if (run_inc == RUN_MAX6 || in_last) begin
                        out_valid <= 1'b1;
                        out_data  <= {QOI_OP_RUN | {2'b00, run_inc - 6'd1}, 32'h0};
                        out_bytes <= 3'd1;
                        out_last  <= in_last;
                        run       <= 6'd0;
                    end else begin
                        out_valid <= 1'b0;
                        run       <= run_inc;
                    end
                    if (in_last) begin
                        prev <= QOI_PX_INIT;
                    end
                end else if (run != 6'd0) begin
                    out_valid <= 1'b1;
                    out_data  <= {QOI_OP_RUN | {2'b00, run - 6'd1}, 32'h0};
                    out_bytes <= 3'd1;
                    out_last  <= 1'b0;
                    run       <= 6'd0;
                    pend_px   <= in_px;
                    pend_last <= in_last;
                    state     <= ST_SPLIT;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= enc_data;
                    out_bytes <= enc_bytes;
                    out_last  <= in_last;
                    prev      <= in_last ? QOI_PX_INIT : in_px;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
